// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the execute-stage HI/LO arithmetic unit.
// Holds the default widths, the aluop codes the unit reacts to, the divide
// FSM state encoding and small op-classification helpers.
package ex_muldiv_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 6;

  // aluop codes shared with the decode stage
  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  function automatic logic is_div_op(input logic [7:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_mac_op(input logic [7:0] op);
    return (op == EXE_MADD_OP) || (op == EXE_MADDU_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_MSUBU_OP);
  endfunction

  // ops whose operands are two's complement
  function automatic logic is_signed_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MADD_OP) ||
           (op == EXE_MSUB_OP) || (op == EXE_DIV_OP);
  endfunction

endpackage

// File: rtl/ex_muldiv_div_iter.sv
// One radix-2 restoring divide step.
// Ports:
//   rem_i     partial remainder (always < divisor_i)
//   bit_i     next dividend bit, MSB first
//   divisor_i unsigned divisor
//   rem_o     partial remainder after this step
//   q_o       quotient bit produced by this step
module ex_muldiv_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // trial < 2*divisor, so the extra MSB of diff is a clean borrow flag
  assign trial = {rem_i, bit_i};
  assign diff  = trial - {1'b0, divisor_i};
  assign q_o   = ~diff[WIDTH];
  assign rem_o = q_o ? diff[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// Execute-stage multi-cycle HI/LO unit: MULT(U), MADD(U), MSUB(U), DIV(U).
// Ports:
//   clk, rst (sync, active-high), flush (aborts any operation)
//   aluop_i, reg1_i, reg2_i  operation and operands from ID/EX
//   hi_i, lo_i               forwarded current HI/LO (MAC accumulate source)
//   hi_o, lo_o, whilo_o      HI/LO write towards EX/MEM
//   stallreq_o               stall request while an operation is in flight
//
// Divide FSM:
//   state       | meaning
//   DIV_FREE    | idle, waiting for a DIV/DIVU
//   DIV_BY_ZERO | divisor was zero, result forced to 0
//   DIV_ON      | one restoring step per cycle, WIDTH steps
//   DIV_END     | result presented for one cycle
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [7:0]       aluop_i,
  input  logic [WIDTH-1:0] reg1_i,
  input  logic [WIDTH-1:0] reg2_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             whilo_o,
  output logic             stallreq_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [2*WIDTH-1:0] mac_tmp_q, mac_tmp_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   dq_q, dq_d;        // dividend shifts out as quotient shifts in
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               quot_neg_q, quot_neg_d;
  logic               rem_neg_q, rem_neg_d;

  logic               op_signed, op_div;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod_abs, product;
  logic [WIDTH-1:0]   iter_rem;
  logic               iter_q;

  assign op_signed = is_signed_op(aluop_i);
  assign op_div    = is_div_op(aluop_i);
  assign abs_a     = (op_signed && reg1_i[WIDTH-1]) ? -reg1_i : reg1_i;
  assign abs_b     = (op_signed && reg2_i[WIDTH-1]) ? -reg2_i : reg2_i;
  assign prod_abs  = (2*WIDTH)'(abs_a) * (2*WIDTH)'(abs_b);
  assign product   = (op_signed && (reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1])) ? -prod_abs : prod_abs;

  ex_muldiv_div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .rem_i     (rem_q),
    .bit_i     (dq_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (iter_rem),
    .q_o       (iter_q)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_d    = 1'b0;
    mac_tmp_d  = mac_tmp_q;
    rem_d      = rem_q;
    dq_d       = dq_q;
    divisor_d  = divisor_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    hi_o       = '0;
    lo_o       = '0;
    whilo_o    = 1'b0;
    stallreq_o = 1'b0;

    if ((aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP)) begin
      {hi_o, lo_o} = product;
      whilo_o      = 1'b1;
    end else if (is_mac_op(aluop_i)) begin
      if (!phase_q) begin
        mac_tmp_d  = product;
        phase_d    = 1'b1;
        stallreq_o = 1'b1;
      end else begin
        if ((aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP))
          {hi_o, lo_o} = {hi_i, lo_i} - mac_tmp_q;
        else
          {hi_o, lo_o} = {hi_i, lo_i} + mac_tmp_q;
        whilo_o = 1'b1;
      end
    end

    case (state_q)
      DIV_FREE: begin
        if (op_div) begin
          stallreq_o = 1'b1;
          cnt_d      = '0;
          if (reg2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d    = DIV_ON;
            rem_d      = '0;
            dq_d       = abs_a;
            divisor_d  = abs_b;
            quot_neg_d = op_signed && (reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1]);
            rem_neg_d  = op_signed && reg1_i[WIDTH-1];
          end
        end
      end
      DIV_BY_ZERO: begin
        if (!op_div) begin
          state_d = DIV_FREE;
        end else begin
          stallreq_o = 1'b1;
          rem_d      = '0;
          dq_d       = '0;
          quot_neg_d = 1'b0;
          rem_neg_d  = 1'b0;
          state_d    = DIV_END;
        end
      end
      DIV_ON: begin
        if (!op_div) begin
          state_d = DIV_FREE;
        end else begin
          stallreq_o = 1'b1;
          rem_d      = iter_rem;
          dq_d       = {dq_q[WIDTH-2:0], iter_q};
          cnt_d      = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) state_d = DIV_END;
        end
      end
      DIV_END: begin
        state_d = DIV_FREE;
        if (op_div) begin
          whilo_o = 1'b1;
          lo_o    = quot_neg_q ? -dq_q : dq_q;
          hi_o    = rem_neg_q ? -rem_q : rem_q;
        end
      end
      default: state_d = DIV_FREE;
    endcase

    // an operation being discarded must not stall or write in its last cycle
    if (rst || flush) begin
      hi_o       = '0;
      lo_o       = '0;
      whilo_o    = 1'b0;
      stallreq_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      mac_tmp_q  <= '0;
      rem_q      <= '0;
      dq_q       <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      mac_tmp_q  <= mac_tmp_d;
      rem_q      <= rem_d;
      dq_q       <= dq_d;
      divisor_q  <= divisor_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv with hand-computed expected values.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [7:0]  aluop;
  logic [31:0] reg1, reg2, hi_in, lo_in;
  logic [31:0] hi_out, lo_out;
  logic        whilo, stallreq;

  int n_checks = 0;
  int n_errors = 0;

  ex_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .aluop_i    (aluop),
    .reg1_i     (reg1),
    .reg2_i     (reg2),
    .hi_i       (hi_in),
    .lo_i       (lo_in),
    .hi_o       (hi_out),
    .lo_o       (lo_out),
    .whilo_o    (whilo),
    .stallreq_o (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // returns 1 time unit after the next rising edge; outputs sampled 1 unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string tag, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                         input int exp_cyc);
    int  n;
    bit  done;
    bit  stall_ok;
    aluop = op; reg1 = a; reg2 = b;
    n = 0; done = 0; stall_ok = 1;
    while (!done && n <= 40) begin
      #1;
      if (whilo) done = 1;
      else begin
        if (!stallreq) stall_ok = 0;
        tick();
        n++;
      end
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_cyc));
    check({tag, "_stall"}, {63'd0, stall_ok & ~stallreq}, 64'd1);
    check({tag, "_hilo"}, {hi_out, lo_out}, {exp_hi, exp_lo});
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    aluop = EXE_MULT_OP; reg1 = 32'd5; reg2 = 32'd3; hi_in = '0; lo_in = '0;
    tick(); tick();
    #1;
    check("reset_outputs", {hi_out, lo_out}, 64'd0);
    check("reset_ctrl", {62'd0, whilo, stallreq}, 64'd0);
    rst = 1'b0;
    tick();

    // MULT -3 * 7
    aluop = EXE_MULT_OP; reg1 = 32'hFFFF_FFFD; reg2 = 32'h0000_0007;
    #1;
    check("mult_hilo", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFEB);
    check("mult_ctrl", {62'd0, whilo, stallreq}, 64'd2);
    tick();

    aluop = EXE_MULTU_OP; reg1 = 32'hFFFF_FFFF; reg2 = 32'hFFFF_FFFF;
    #1;
    check("multu_hilo", {hi_out, lo_out}, 64'hFFFF_FFFE_0000_0001);
    tick();

    aluop = 8'h25; // unrelated op
    #1;
    check("other_op_ctrl", {62'd0, whilo, stallreq}, 64'd0);
    tick();

    // MADDU {0,FFFFFFFF} + 2*3
    aluop = EXE_MADDU_OP; hi_in = 32'h0; lo_in = 32'hFFFF_FFFF; reg1 = 32'd2; reg2 = 32'd3;
    #1;
    check("maddu_c0_ctrl", {62'd0, whilo, stallreq}, 64'd1);
    tick();
    #1;
    check("maddu_c1_hilo", {hi_out, lo_out}, 64'h0000_0001_0000_0005);
    check("maddu_c1_ctrl", {62'd0, whilo, stallreq}, 64'd2);
    tick();

    // MSUB {0,5} - (-1*2) = 7
    aluop = EXE_MSUB_OP; hi_in = 32'h0; lo_in = 32'd5; reg1 = 32'hFFFF_FFFF; reg2 = 32'd2;
    #1;
    check("msub_c0_ctrl", {62'd0, whilo, stallreq}, 64'd1);
    tick();
    #1;
    check("msub_c1_hilo", {hi_out, lo_out}, 64'd7);
    check("msub_c1_ctrl", {62'd0, whilo, stallreq}, 64'd2);
    tick();
    aluop = EXE_NOP_OP; tick();

    run_div("div_neg_pos", EXE_DIV_OP, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    aluop = EXE_NOP_OP; tick();
    run_div("div_pos_neg", EXE_DIV_OP, 32'h7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h1, 33);
    aluop = EXE_NOP_OP; tick();
    run_div("divu_max_by_1", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h0, 33);
    aluop = EXE_NOP_OP; tick();
    run_div("divu_by_zero", EXE_DIVU_OP, 32'd5, 32'd0, 32'd0, 32'd0, 2);
    aluop = EXE_NOP_OP; tick();
    run_div("div_by_zero_neg", EXE_DIV_OP, 32'h8000_0000, 32'd0, 32'd0, 32'd0, 2);
    aluop = EXE_NOP_OP; tick();

    // flush while in ON with cnt=10 (cycle 11), then reissue from scratch
    aluop = EXE_DIVU_OP; reg1 = 32'd100; reg2 = 32'd7;
    repeat (11) tick();
    flush = 1'b1;
    #1;
    check("flush_ctrl", {62'd0, whilo, stallreq}, 64'd0);
    tick();
    flush = 1'b0;
    run_div("divu_after_flush", EXE_DIVU_OP, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    aluop = EXE_NOP_OP; tick();

    // abort by op change while ON
    aluop = EXE_DIVU_OP; reg1 = 32'd50; reg2 = 32'd5;
    repeat (5) tick();
    aluop = EXE_NOP_OP;
    #1;
    check("abort_ctrl", {62'd0, whilo, stallreq}, 64'd0);
    tick();
    run_div("divu_after_abort", EXE_DIVU_OP, 32'd50, 32'd5, 32'd10, 32'd0, 33);

    // reset mid-divide, then back-to-back divides
    aluop = EXE_DIVU_OP; reg1 = 32'd9; reg2 = 32'd3;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    check("rst_mid_div", {hi_out, lo_out, 30'd0, whilo, stallreq}, 96'd0);
    tick();
    rst = 1'b0;
    run_div("b2b_first", EXE_DIVU_OP, 32'd9, 32'd3, 32'd3, 32'd0, 33);
    run_div("b2b_second", EXE_DIVU_OP, 32'd10, 32'd4, 32'd2, 32'd2, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
